// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: sequencer one-hot states, memory-controller FSM encodings and access-kind type
package mem_ctrl_pkg;
  localparam int CONTROL_BIT_MAX = 5;
  localparam logic [CONTROL_BIT_MAX:0] STATE_FETCH     = 6'b000001;
  localparam logic [CONTROL_BIT_MAX:0] STATE_DECODE    = 6'b000010;
  localparam logic [CONTROL_BIT_MAX:0] STATE_REG_READ  = 6'b000100;
  localparam logic [CONTROL_BIT_MAX:0] STATE_ALU       = 6'b001000;
  localparam logic [CONTROL_BIT_MAX:0] STATE_MEM       = 6'b010000;
  localparam logic [CONTROL_BIT_MAX:0] STATE_WRITEBACK = 6'b100000;
  localparam int MEMC_STATE_MAX = 1;
  typedef enum logic [MEMC_STATE_MAX:0] {
    MEMC_IDLE = 2'd0,
    MEMC_LO   = 2'd1,
    MEMC_HI   = 2'd2,
    MEMC_DONE = 2'd3
  } memc_state_e;
  typedef struct packed {
    logic write;
    logic byte_acc;
  } memc_kind_t;
endpackage

// File: rtl/mem_ctrl.sv
// mem_ctrl: serves 16-bit fetch/load/store (control_i, pc_i, addr_i, data_i, mem_we, mem_byte -> data_o, mem_wait) as 8-bit beats on an external SRAM bus (ext_*)
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CONTROL_BIT_MAX:0] control_i,
  input  logic [15:0]              pc_i,
  input  logic [15:0]              addr_i,
  input  logic [15:0]              data_i,
  input  logic                     mem_we,
  input  logic                     mem_byte,
  output logic [15:0]              data_o,
  output logic                     mem_wait,
  output logic [15:0]              ext_addr,
  output logic [7:0]               ext_dout,
  input  logic [7:0]               ext_din,
  output logic                     ext_cs,
  output logic                     ext_oe,
  output logic                     ext_we
);
  memc_state_e state_q, state_d;
  memc_kind_t  kind_q, kind_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, data_q, data_d, ext_addr_q, ext_addr_d;
  logic [7:0]  lo_q, lo_d, ext_dout_q, ext_dout_d;
  logic        ext_cs_q, ext_cs_d, ext_oe_q, ext_oe_d, ext_we_q, ext_we_d;
  logic        req, fetch, latch, beat_end, beat_d, rd_done;
  assign fetch    = control_i == STATE_FETCH;
  assign req      = fetch || control_i == STATE_MEM;
  assign beat_end = cnt_q == 4'd0;
  assign mem_wait = req && state_q != MEMC_DONE;
  assign data_o   = data_q;
  assign ext_addr = ext_addr_q;
  assign ext_dout = ext_dout_q;
  assign ext_cs   = ext_cs_q;
  assign ext_oe   = ext_oe_q;
  assign ext_we   = ext_we_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEMC_IDLE;
      kind_q     <= '0;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      data_q     <= '0;
      lo_q       <= '0;
      ext_addr_q <= '0;
      ext_dout_q <= '0;
      ext_cs_q   <= 1'b0;
      ext_oe_q   <= 1'b0;
      ext_we_q   <= 1'b0;
    end else if (en) begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      lo_q       <= lo_d;
      ext_addr_q <= ext_addr_d;
      ext_dout_q <= ext_dout_d;
      ext_cs_q   <= ext_cs_d;
      ext_oe_q   <= ext_oe_d;
      ext_we_q   <= ext_we_d;
    end
  end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      MEMC_IDLE: state_d = req ? MEMC_LO : MEMC_IDLE;
      MEMC_LO:   state_d = !req ? MEMC_IDLE : !beat_end ? MEMC_LO : kind_q.byte_acc ? MEMC_DONE : MEMC_HI;
      MEMC_HI:   state_d = !req ? MEMC_IDLE : beat_end ? MEMC_DONE : MEMC_HI;
      default:   state_d = MEMC_IDLE;
    endcase
  end
  always_comb begin
    latch      = state_q == MEMC_IDLE && req;
    addr_d     = latch ? (fetch ? pc_i : addr_i) : addr_q;
    wdata_d    = latch ? data_i : wdata_q;
    kind_d     = latch ? memc_kind_t'{write: !fetch && mem_we, byte_acc: !fetch && mem_byte} : kind_q;
    beat_d     = state_d == MEMC_LO || state_d == MEMC_HI;
    cnt_d      = (beat_d && state_d != state_q) ? 4'(WAIT_CYCLES) : cnt_q - 4'(cnt_q != 4'd0);
    lo_d       = (state_q == MEMC_LO && beat_end) ? ext_din : lo_q;
    rd_done    = state_d == MEMC_DONE && !kind_q.write;
    data_d     = rd_done ? (kind_q.byte_acc ? {8'h00, ext_din} : {ext_din, lo_q}) : data_q;
    ext_cs_d   = beat_d;
    ext_oe_d   = beat_d && !kind_d.write;
    ext_we_d   = beat_d && kind_d.write;
    ext_addr_d = state_d == MEMC_HI ? {addr_d[15:1], 1'b1} : kind_d.byte_acc ? addr_d : {addr_d[15:1], 1'b0};
    ext_dout_d = state_d == MEMC_HI ? wdata_d[15:8] : wdata_d[7:0];
  end
`ifdef FORMAL
  always_comb begin
    assert (!(mem_wait && state_q == MEMC_DONE));
    assert (!(ext_oe_q && ext_we_q));
    assert (!(ext_cs_q || ext_oe_q || ext_we_q) || state_q == MEMC_LO || state_q == MEMC_HI);
  end
`endif
endmodule
